// File: rtl/voice_allocator.sv
// voice_allocator
//   Polyphonic voice scheduler. Scans NUM_KEYS active-low keys, one key per
//   clock, and assigns each newly pressed key to the lowest free oscillator
//   voice. Drives per-voice gate, pitch word, key index and a retrigger pulse.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   btn          in   [NUM_KEYS]           raw keys, active-low, asynchronous
//   voice_gate   out  [NUM_VOICES]         1 = voice sounding
//   voice_pitch  out  [NUM_VOICES*PITCH_W] pitch word of voice v at [PITCH_W*v +: PITCH_W]
//   voice_key    out  [NUM_VOICES*KEY_W]   key index held by voice v
//   voice_retrig out  [NUM_VOICES]         1-cycle pulse when a voice is (re)assigned
//   steal_pulse  out                       1-cycle pulse when a busy voice is reassigned
//
// Configuration
//   VOICE_STEAL_EN  when defined, a press with every voice gated steals the
//                   voice with the largest age (lowest index on a tie).
//                   When undefined, such a press is recorded but dropped and
//                   steal_pulse is tied low.
module voice_allocator #(
  parameter int NUM_VOICES = 3,
  parameter int NUM_KEYS   = 8,
  parameter int PITCH_W    = 16,
  parameter int AGE_W      = 8,
  localparam int KEY_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int VIDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_KEYS-1:0]           btn,
  output logic [NUM_VOICES-1:0]         voice_gate,
  output logic [NUM_VOICES*PITCH_W-1:0] voice_pitch,
  output logic [NUM_VOICES*KEY_W-1:0]   voice_key,
  output logic [NUM_VOICES-1:0]         voice_retrig,
  output logic                          steal_pulse
);

  logic [NUM_KEYS-1:0]              btn_meta;
  logic [NUM_KEYS-1:0]              btn_sync;
  logic [NUM_KEYS-1:0]              stored;
  logic [KEY_W-1:0]                 idx;
  logic [NUM_VOICES-1:0][AGE_W-1:0] age;

  logic              cur_pressed;
  logic              press_evt;
  logic              release_evt;
  logic              scan_wrap;
  logic              free_found;
  logic [VIDX_W-1:0] free_idx;
  logic              alloc_en;
  logic [VIDX_W-1:0] alloc_idx;

  function automatic logic [PITCH_W-1:0] pitch_rom(input logic [KEY_W-1:0] k);
    case (int'(k))
      0:       return PITCH_W'(15289);
      1:       return PITCH_W'(13621);
      2:       return PITCH_W'(12135);
      3:       return PITCH_W'(11454);
      4:       return PITCH_W'(10204);
      5:       return PITCH_W'(9091);
      6:       return PITCH_W'(8099);
      7:       return PITCH_W'(7645);
      default: return '0;
    endcase
  endfunction

  // NOTE: synchroniser flops reset to the released level (1) so that
  // leaving reset never looks like a press on every key at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= '1;
      btn_sync <= '1;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

  assign cur_pressed = ~btn_sync[idx];
  assign press_evt   = cur_pressed & ~stored[idx];
  assign release_evt = ~cur_pressed & stored[idx];
  assign scan_wrap   = (idx == KEY_W'(NUM_KEYS - 1));

`ifdef VOICE_STEAL_EN
  logic              steal_en;
  logic [VIDX_W-1:0] oldest_idx;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned (which would infer a latch).
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    // Descending walk: the last hit, i.e. the lowest free index, wins.
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!voice_gate[v]) begin
        free_found = 1'b1;
        free_idx   = VIDX_W'(v);
      end
    end
    alloc_en  = press_evt & free_found;
    alloc_idx = free_idx;
`ifdef VOICE_STEAL_EN
    // Strict '>' keeps the lowest index on equal ages.
    oldest_idx = '0;
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age[v] > age[oldest_idx]) oldest_idx = VIDX_W'(v);
    end
    steal_en = press_evt & ~free_found;
    if (steal_en) begin
      alloc_en  = 1'b1;
      alloc_idx = oldest_idx;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      stored       <= '0;
      age          <= '0;
      voice_gate   <= '0;
      voice_pitch  <= '0;
      voice_key    <= '0;
      voice_retrig <= '0;
    end else begin
      idx          <= scan_wrap ? '0 : idx + 1'b1;
      voice_retrig <= '0;

      if (press_evt)   stored[idx] <= 1'b1;
      if (release_evt) stored[idx] <= 1'b0;

      for (int v = 0; v < NUM_VOICES; v++) begin
        if (scan_wrap && voice_gate[v] && (age[v] != '1))
          age[v] <= age[v] + 1'b1;

        if (release_evt && voice_gate[v] && (voice_key[v*KEY_W +: KEY_W] == idx))
          voice_gate[v] <= 1'b0;

        // Allocation is placed last so it overrides the age update above.
        if (alloc_en && (alloc_idx == VIDX_W'(v))) begin
          voice_gate[v]                    <= 1'b1;
          voice_key[v*KEY_W +: KEY_W]      <= idx;
          voice_pitch[v*PITCH_W +: PITCH_W] <= pitch_rom(idx);
          age[v]                           <= '0;
          voice_retrig[v]                  <= 1'b1;
        end
      end
    end
  end

`ifdef VOICE_STEAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) steal_pulse <= 1'b0;
    else        steal_pulse <= steal_en;
  end
`else
  assign steal_pulse = 1'b0;
`endif

endmodule
